ex_mul_unit: RTL and testbench

//  Multi-cycle iterative multiplier in the EX stage, fed by the D->EX pipeline register.
//  - Captures EX_a/EX_b/EX_rd/EX_we when EX_mul is set.
//  - Computes the low XLEN bits of a*b, one shift-add step per cycle.
//  - Holds mul_stall high while working. Upstream stages freeze and bubbles enter EX.
//  - Presents the result for one cycle to the EX->MEM path.

---
 rtl/ex_mul_unit_pkg.sv | 22 ++
 rtl/ex_mul_unit_if.sv | 44 ++++
 rtl/ex_mul_unit.sv | 129 ++++++++++++
 tb/tb_ex_mul_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mul_unit_pkg.sv
// ---------------------------------------------------------------------------
// ex_mul_unit_pkg
//   Shared pipeline constants for the EX-stage iterative multiplier.
//   - MUL_IDLE / MUL_BUSY / MUL_DONE : 2-bit state encodings
//   - REG_IDX_W                      : register-index width
//   - mul_state_e                    : FSM state type built on those encodings
// ---------------------------------------------------------------------------
package ex_mul_unit_pkg;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = MUL_IDLE,
        ST_BUSY = MUL_BUSY,
        ST_DONE = MUL_DONE
    } mul_state_e;

endpackage

// File: rtl/ex_mul_unit_if.sv
// ---------------------------------------------------------------------------
// ex_mul_unit_if
//   Bundle between the D->EX pipeline register / hazard logic and the EX-stage
//   multiplier.
//   master (pipeline side) drives : EX_mul, EX_a, EX_b, EX_rd, EX_we, mul_kill
//   slave  (multiplier) drives    : mul_stall, mul_valid, mul_result, mul_rd,
//                                   mul_we, mul_state (FSM state, debug only)
//
//   Handshake: a multiply is accepted on the rising edge where EX_mul=1,
//   mul_kill=0 and the unit is IDLE or DONE.  mul_stall is combinational and
//   rises in the same cycle EX_mul appears, so the upstream stages freeze
//   immediately.  mul_valid is a one-cycle result strobe with no back-pressure;
//   mul_result/mul_rd/mul_we are zero whenever mul_valid is low.
// ---------------------------------------------------------------------------
interface ex_mul_unit_if #(
    parameter int XLEN = 32
);
    import ex_mul_unit_pkg::*;

    logic                 EX_mul;
    logic [XLEN-1:0]      EX_a;
    logic [XLEN-1:0]      EX_b;
    logic [REG_IDX_W-1:0] EX_rd;
    logic                 EX_we;
    logic                 mul_kill;

    logic                 mul_stall;
    logic                 mul_valid;
    logic [XLEN-1:0]      mul_result;
    logic [REG_IDX_W-1:0] mul_rd;
    logic                 mul_we;
    mul_state_e           mul_state;

    modport master (
        output EX_mul, EX_a, EX_b, EX_rd, EX_we, mul_kill,
        input  mul_stall, mul_valid, mul_result, mul_rd, mul_we, mul_state
    );

    modport slave (
        input  EX_mul, EX_a, EX_b, EX_rd, EX_we, mul_kill,
        output mul_stall, mul_valid, mul_result, mul_rd, mul_we, mul_state
    );

endinterface

// File: rtl/ex_mul_unit.sv
// ---------------------------------------------------------------------------
// ex_mul_unit
//   Iterative shift-add multiplier in the EX stage.  Produces the low XLEN
//   bits of EX_a*EX_b, one partial product per BUSY cycle, while holding the
//   front of the pipeline with mul_stall.  The result is presented for a
//   single DONE cycle.
//
//   Parameters
//     XLEN        operand/result width (>=2)
//     EARLY_EXIT  1: stop once the remaining multiplier is zero
//                 0: always XLEN BUSY steps
//   Ports
//     clk     in   rising-edge clock
//     rst     in   asynchronous active-high reset
//     mul_if  slave modport of ex_mul_unit_if (operands in, result/stall out)
// ---------------------------------------------------------------------------
module ex_mul_unit
    import ex_mul_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    ex_mul_unit_if.slave mul_if
);

    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    mul_state_e           r_state;
    mul_state_e           w_next_state;

    logic [XLEN-1:0]      r_acc;
    logic [XLEN-1:0]      r_mcand;
    logic [XLEN-1:0]      r_mplier;
    logic [CNT_W-1:0]     r_count;
    logic [REG_IDX_W-1:0] r_rd;
    logic                 r_we;

    logic                 w_idle_or_done;
    logic                 w_accept;
    logic                 w_last_step;
    logic                 w_valid;
    logic [XLEN-1:0]      w_acc_sum;

    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept       = w_idle_or_done & mul_if.EX_mul & ~mul_if.mul_kill;

    // Terminal step: either the last bit position, or (early exit) nothing
    // left in the multiplier after this step's shift.
    assign w_last_step = (r_count == CNT_LAST) ||
                         (EARLY_EXIT && (r_mplier[XLEN-1:1] == '0));

    assign w_acc_sum = r_acc + r_mcand;

    // A kill in the DONE cycle suppresses the strobe for that op.
    assign w_valid = (r_state == ST_DONE) & ~mul_if.mul_kill;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (mul_if.mul_kill) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (mul_if.EX_mul) w_next_state = ST_BUSY;
                ST_BUSY: if (w_last_step)   w_next_state = ST_DONE;
                ST_DONE: w_next_state = mul_if.EX_mul ? ST_BUSY : ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator plus shifting multiplicand / multiplier
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_rd     <= '0;
            r_we     <= 1'b0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= mul_if.EX_a;
            r_mplier <= mul_if.EX_b;
            r_count  <= '0;
            r_rd     <= mul_if.EX_rd;
            r_we     <= mul_if.EX_we;
        end else if ((r_state == ST_BUSY) && !mul_if.mul_kill) begin
            if (r_mplier[0]) begin
                r_acc <= w_acc_sum;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            // Hold on the terminal step so the counter never wraps.
            if (!w_last_step) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // rst gates the stall so every output is low while reset is held, even
    // if EX_mul is asserted.
    assign mul_if.mul_stall  = ~rst & ~mul_if.mul_kill &
                               ((r_state == ST_BUSY) | (w_idle_or_done & mul_if.EX_mul));
    assign mul_if.mul_valid  = w_valid;
    assign mul_if.mul_result = w_valid ? r_acc : '0;
    assign mul_if.mul_rd     = w_valid ? r_rd  : '0;
    assign mul_if.mul_we     = w_valid & r_we;
    assign mul_if.mul_state  = r_state;

endmodule

// File: tb/tb_ex_mul_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_mul_unit
//   Two instances: dut0 with EARLY_EXIT=0, dut1 with EARLY_EXIT=1, each on its
//   own interface.  Inputs are driven 1 time unit after a rising edge and
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ex_mul_unit;
    import ex_mul_unit_pkg::*;

    localparam int XLEN = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    ex_mul_unit_if #(.XLEN(XLEN)) if0 ();
    ex_mul_unit_if #(.XLEN(XLEN)) if1 ();

    ex_mul_unit #(.XLEN(XLEN), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst(rst), .mul_if(if0));
    ex_mul_unit #(.XLEN(XLEN), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst(rst), .mul_if(if1));

    logic            drv_mul  [2];
    logic [XLEN-1:0] drv_a    [2];
    logic [XLEN-1:0] drv_b    [2];
    logic [4:0]      drv_rd   [2];
    logic            drv_we   [2];
    logic            drv_kill [2];

    logic            obs_stall [2];
    logic            obs_valid [2];
    logic [XLEN-1:0] obs_res   [2];
    logic [4:0]      obs_rd    [2];
    logic            obs_we    [2];
    logic [1:0]      obs_state [2];

    assign if0.EX_mul   = drv_mul[0];
    assign if0.EX_a     = drv_a[0];
    assign if0.EX_b     = drv_b[0];
    assign if0.EX_rd    = drv_rd[0];
    assign if0.EX_we    = drv_we[0];
    assign if0.mul_kill = drv_kill[0];
    assign if1.EX_mul   = drv_mul[1];
    assign if1.EX_a     = drv_a[1];
    assign if1.EX_b     = drv_b[1];
    assign if1.EX_rd    = drv_rd[1];
    assign if1.EX_we    = drv_we[1];
    assign if1.mul_kill = drv_kill[1];

    assign obs_stall[0] = if0.mul_stall;
    assign obs_valid[0] = if0.mul_valid;
    assign obs_res[0]   = if0.mul_result;
    assign obs_rd[0]    = if0.mul_rd;
    assign obs_we[0]    = if0.mul_we;
    assign obs_state[0] = if0.mul_state;
    assign obs_stall[1] = if1.mul_stall;
    assign obs_valid[1] = if1.mul_valid;
    assign obs_res[1]   = if1.mul_result;
    assign obs_rd[1]    = if1.mul_rd;
    assign obs_we[1]    = if1.mul_we;
    assign obs_state[1] = if1.mul_state;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] model_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        return p[XLEN-1:0];
    endfunction

    // BUSY cycles: XLEN without early exit; otherwise one per bit up to the
    // highest set bit of the multiplier, never fewer than one.
    function automatic int model_busy(input int early, input logic [XLEN-1:0] b);
        if (early == 0) return XLEN;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle(input int d);
        drv_mul[d]  = 1'b0;
        drv_a[d]    = '0;
        drv_b[d]    = '0;
        drv_rd[d]   = '0;
        drv_we[d]   = 1'b0;
        drv_kill[d] = 1'b0;
    endtask

    task automatic drive_op(input int d, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [4:0] rd, input logic we);
        drv_mul[d] = 1'b1;
        drv_a[d]   = a;
        drv_b[d]   = b;
        drv_rd[d]  = rd;
        drv_we[d]  = we;
    endtask

    // One complete multiply from the IDLE state; checks result, rd/we,
    // stall length, single strobe and zeroed outputs afterwards.
    task automatic run_op(input int d, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [4:0] rd, input logic we,
                          input logic [XLEN-1:0] exp_res, input int exp_stall, input string name);
        int stall_n = 0;
        int valid_n = 0;
        bit seen    = 0;
        exp_q.push_back(exp_res);
        drive_op(d, a, b, rd, we);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (obs_stall[d]) stall_n++;
            if (obs_valid[d]) begin
                valid_n++;
                seen = 1;
                if (exp_q.size() > 0) chk({name, " result"}, obs_res[d], exp_q.pop_front());
                chk({name, " rd"}, obs_rd[d], rd);
                chk({name, " we"}, obs_we[d], we);
            end else if (seen) begin
                chk({name, " outputs zero after strobe"},
                    {obs_stall[d], obs_res[d], obs_rd[d], obs_we[d]}, 0);
            end
            next_cyc();
            drv_mul[d] = 1'b0;
            if (seen && !obs_valid[d]) break;
        end
        chk({name, " completed"}, seen, 1);
        chk({name, " stall cycles"}, stall_n, exp_stall);
        chk({name, " valid count"}, valid_n, 1);
        exp_q.delete();
        drive_idle(d);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int              d;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] exp_res;
        int              exp_stall;
    } vec_t;

    vec_t vecs[8];

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        int n1;
        int n2;
        int vcnt;
        bit stall_seen;

        vecs[0] = '{0, 32'd6,          32'd7,          5'd3,  1'b1, 32'd42,         33};
        vecs[1] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  1'b1, 32'h0000_0001,  33};
        vecs[2] = '{0, 32'h8000_0000,  32'd2,          5'd9,  1'b0, 32'h0000_0000,  33};
        vecs[3] = '{1, 32'h0000_1234,  32'd1,          5'd10, 1'b1, 32'h0000_1234,  2};
        vecs[4] = '{1, 32'd5,          32'd0,          5'd11, 1'b1, 32'd0,          2};
        vecs[5] = '{1, 32'd3,          32'h8000_0000,  5'd12, 1'b0, 32'h8000_0000,  33};
        vecs[6] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31, 1'b1, 32'h0000_0001,  33};
        vecs[7] = '{0, 32'd5,          32'd0,          5'd1,  1'b1, 32'd0,          33};

        // Reset, with EX_mul held high on dut1 to show the stall stays low.
        rst = 1'b1;
        drive_idle(0);
        drive_idle(1);
        drive_op(1, 32'd3, 32'd3, 5'd1, 1'b1);
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("reset outputs", {obs_stall[d], obs_valid[d], obs_res[d], obs_rd[d], obs_we[d]}, 0);
            chk("reset state", obs_state[d], MUL_IDLE);
        end
        drive_idle(1);
        #9 rst = 1'b0;
        next_cyc();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("post-reset outputs", {obs_stall[d], obs_valid[d], obs_res[d], obs_rd[d], obs_we[d]}, 0);
        end
        next_cyc();

        // Directed table.
        foreach (vecs[i]) begin
            run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].we,
                   vecs[i].exp_res, vecs[i].exp_stall, $sformatf("vec%0d", i));
        end

        // Back-to-back on dut1: op2 issued in op1's DONE cycle.
        n1 = model_busy(1, 32'd3);
        n2 = model_busy(1, 32'd9);
        for (int c = 0; c <= n1 + n2 + 3; c++) begin
            if (c == 0)            drive_op(1, 32'd5, 32'd3, 5'd4, 1'b1);
            else if (c == n1 + 1)  drive_op(1, 32'd7, 32'd9, 5'd6, 1'b0);
            else                   drv_mul[1] = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b stall c%0d", c), obs_stall[1], (c <= n1 + n2 + 1));
            chk($sformatf("b2b valid c%0d", c), obs_valid[1], (c == n1 + 1) || (c == n1 + n2 + 2));
            if (c == n1 + 1) begin
                chk("b2b op1 result", obs_res[1], model_mul(32'd5, 32'd3));
                chk("b2b op1 rd/we", {obs_rd[1], obs_we[1]}, {5'd4, 1'b1});
            end
            if (c == n1 + n2 + 2) begin
                chk("b2b op2 result", obs_res[1], model_mul(32'd7, 32'd9));
                chk("b2b op2 rd/we", {obs_rd[1], obs_we[1]}, {5'd6, 1'b0});
            end
            next_cyc();
        end
        drive_idle(1);

        // Kill in BUSY cycle 10 on dut0.
        drive_op(0, 32'd6, 32'd7, 5'd2, 1'b1);
        next_cyc();
        drv_mul[0] = 1'b0;
        for (int k = 1; k < 10; k++) next_cyc();
        drv_kill[0] = 1'b1;
        @(negedge clk);
        chk("kill cycle stall", obs_stall[0], 0);
        chk("kill cycle valid", obs_valid[0], 0);
        next_cyc();
        drv_kill[0] = 1'b0;
        @(negedge clk);
        chk("after kill state", obs_state[0], MUL_IDLE);
        vcnt = 0;
        stall_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (obs_valid[0]) vcnt++;
            if (obs_stall[0]) stall_seen = 1;
        end
        chk("killed op valid count", vcnt, 0);
        chk("killed op stall after kill", stall_seen, 0);
        next_cyc();

        // Kill together with EX_mul in IDLE: not accepted.
        drive_op(0, 32'd2, 32'd2, 5'd5, 1'b1);
        drv_kill[0] = 1'b1;
        @(negedge clk);
        chk("kill+mul stall", obs_stall[0], 0);
        next_cyc();
        drive_idle(0);
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (obs_valid[0] || obs_stall[0]) vcnt++;
        end
        chk("kill+mul not accepted", vcnt, 0);
        next_cyc();
        run_op(0, 32'd2, 32'd2, 5'd5, 1'b1, 32'd4, 33, "post-kill");

        // Asynchronous reset mid-BUSY on dut1.
        drive_op(1, 32'd3, 32'h8000_0000, 5'd8, 1'b1);
        next_cyc();
        drv_mul[1] = 1'b0;
        for (int k = 0; k < 5; k++) next_cyc();
        chk("pre-reset busy stall", obs_stall[1], 1);
        #2 rst = 1'b1;
        #1;
        chk("async reset stall", obs_stall[1], 0);
        chk("async reset outputs", {obs_valid[1], obs_res[1], obs_rd[1], obs_we[1]}, 0);
        chk("async reset state", obs_state[1], MUL_IDLE);
        @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (obs_valid[1]) vcnt++;
        end
        chk("reset discards result", vcnt, 0);
        next_cyc();
        run_op(1, 32'd3, 32'd3, 5'd13, 1'b1, 32'd9, 3, "post-reset 3*3");

        // Random operands, latency varied through the multiplier width.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) begin
                logic [XLEN-1:0] a;
                logic [XLEN-1:0] b;
                logic [4:0]      rd;
                logic            we;
                a  = $urandom;
                b  = $urandom >> $urandom_range(0, 31);
                rd = 5'($urandom_range(0, 31));
                we = 1'($urandom_range(0, 1));
                run_op(d, a, b, rd, we, model_mul(a, b), model_busy(d, b) + 1,
                       $sformatf("rand d%0d #%0d", d, i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
